// File: rtl/mux_tdm.sv
// mux_tdm: CH-channel, W-bit time-division multiplexer with a one-entry
// registered output stage and a valid/ready handshake. Supports manual
// channel selection (key) and round-robin scan with DWELL loads per channel.
// Optional feature macro: MUX_TDM_MASK_EN enables the scan-mode channel mask.
// When the macro is undefined, mask is ignored and every channel is scanned.
module mux_tdm #(
  parameter  int CH    = 4,
  parameter  int W     = 1,
  parameter  int DWELL = 4,
  localparam int KW    = $clog2(CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH*W-1:0] data,
  input  logic [KW-1:0]   key,
  input  logic            mode,
  input  logic [CH-1:0]   mask,
  output logic [W-1:0]    out,
  output logic [KW-1:0]   out_ch,
  output logic            out_valid,
  input  logic            out_ready
);

  localparam int            CW       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
  localparam logic [KW-1:0] PTR_LAST = KW'(CH - 1);

  logic [W-1:0]  out_q, out_d;
  logic [KW-1:0] out_ch_q, out_ch_d;
  logic          out_valid_q, out_valid_d;
  logic [KW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mode_q, mode_d;

  logic          ld_ok;
  logic          scan_start;
  logic [KW-1:0] ptr_eff;
  logic [CW-1:0] cnt_eff;
  logic [KW-1:0] sel;
  logic [W-1:0]  sample;
  logic          do_load;

  // Decode the load window, the scan-start edge and the channel to sample.
  // NOTE: every signal written in an always_comb gets a default at the top so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    ld_ok      = !out_valid_q || out_ready;
    scan_start = mode && !mode_q;
    ptr_eff    = scan_start ? '0 : ptr_q;
    cnt_eff    = scan_start ? '0 : cnt_q;
    sel        = mode ? ptr_eff : key;
  end

  // Channel select mux; an index past the last channel yields zero.
  always_comb begin
    sample = '0;
    for (int i = 0; i < CH; i++) begin
      if (sel == KW'(i)) sample = data[i*W +: W];
    end
  end

`ifdef MUX_TDM_MASK_EN
  logic [KW-1:0] mask_nxt;
  logic [KW-1:0] mask_cand;
  logic          mask_found;

  // Circular search for the next enabled channel, starting just after ptr.
  always_comb begin
    mask_nxt   = ptr_eff;
    mask_cand  = ptr_eff;
    mask_found = 1'b0;
    for (int k = 1; k <= CH; k++) begin
      mask_cand = KW'((int'(ptr_eff) + k) % CH);
      if (!mask_found && mask[mask_cand]) begin
        mask_found = 1'b1;
        mask_nxt   = mask_cand;
      end
    end
  end
`else
  logic unused_mask;
  assign unused_mask = ^mask;
`endif

  // Next-state logic for the output stage and the scan pointer/dwell counter.
  always_comb begin
    out_d       = out_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q && !out_ready;
    ptr_d       = ptr_eff;
    cnt_d       = cnt_eff;
    mode_d      = mode;
    do_load     = 1'b0;

    if (ld_ok) begin
      if (!mode) begin
        do_load = 1'b1;
      end else begin
`ifdef MUX_TDM_MASK_EN
        if (mask[ptr_eff]) begin
          do_load = 1'b1;
        end else begin
          // Disabled channel: spend this cycle moving to the next enabled one.
          ptr_d = mask_nxt;
          cnt_d = '0;
        end
`else
        do_load = 1'b1;
`endif
      end
    end

    if (do_load) begin
      out_d       = sample;
      out_ch_d    = sel;
      out_valid_d = 1'b1;
      if (mode) begin
        if (cnt_eff == CNT_LAST) begin
          cnt_d = '0;
          ptr_d = (ptr_eff == PTR_LAST) ? '0 : ptr_eff + 1'b1;
        end else begin
          cnt_d = cnt_eff + 1'b1;
        end
      end
    end
  end

  // State registers with synchronous active-high reset.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its input from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
    end
  end

  assign out       = out_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule

// File: doc/mux_tdm.md
# mux_tdm

Parametrised N-channel, W-bit time-division multiplexer with a one-entry registered output stage and a valid/ready handshake. It supports manual channel selection and an automatic round-robin scan with a programmable dwell count per channel. It replaces fixed-size combinational select muxes wherever a channel stream must feed a downstream consumer that can stall.

## Interface
Parameters:
- CH, 4, number of input channels; must be ≥ 2.
- W, 1, bits per channel; must be ≥ 1.
- DWELL, 4, consecutive loads per channel in scan mode; must be ≥ 1.
- Derived: KW = $clog2(CH).

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- data  in  CH*W  channel i is data[i*W +: W].
- key  in  KW  channel select in manual mode.
- mode  in  1  0 = manual, 1 = scan.
- mask  in  CH  channel enable mask for scan mode; used only with MUX_TDM_MASK_EN.
- out  out  W  registered sample.
- out_ch  out  KW  channel index of the sample in `out`.
- out_valid  out  1  `out` holds an unconsumed sample.
- out_ready  in  1  consumer accepts `out` on this edge when out_valid is 1.

## Operation
- Load condition is `ld_ok = !out_valid || out_ready`. A load captures a new sample into `out`/`out_ch` and sets out_valid = 1.
- If out_valid = 1 and out_ready = 1 but no load occurs, out_valid clears.
- Manual mode:
  - Every cycle with ld_ok, load data[key] with out_ch = key.
  - If key ≥ CH (CH not a power of two), load out = 0 with out_ch = key.
- Scan mode uses internal pointer ptr (KW bits) and dwell counter cnt.
  - Each load samples channel ptr and sets out_ch = ptr.
  - On each load: if cnt == DWELL-1, then cnt ← 0 and ptr ← ptr+1, wrapping from CH-1 to 0. Otherwise cnt ← cnt+1.
  - ptr and cnt change only on loads. Under backpressure they are frozen and no channel is skipped.
- Mode transitions:
  - A registered copy mode_q detects a 0→1 edge of mode. On that cycle ptr ← 0, cnt ← 0, and the load (if ld_ok) samples channel 0.
  - Scan→manual: ptr and cnt are held but unused.
- Simultaneous events:
  - rst overrides everything.
  - A handshake and a new load on the same edge is a normal back-to-back transfer: out_valid stays 1.

## Timing
- Reset state (one edge of rst = 1): out = 0, out_ch = 0, out_valid = 0, ptr = 0, cnt = 0, mode_q = 0.
- rst asserted mid-transfer discards the held sample. The first load after release comes from key (manual) or channel 0 (scan).
- Latency: the data sampled at edge t appears on `out` after edge t.
- Throughput: one sample per cycle while out_ready = 1.
- While out_valid = 1 and out_ready = 0, out and out_ch are stable.

## Configuration
- MUX_TDM_MASK_EN defined:
  - In scan mode, when ld_ok and mask[ptr] = 0, no load occurs. Instead ptr advances to the next set mask bit, searching circularly from ptr+1, and cnt ← 0. This costs one bubble cycle.
  - If mask = 0, no scan loads occur and out_valid clears once the held sample is consumed.
  - A mask change takes effect at the next ptr evaluation.
- MUX_TDM_MASK_EN undefined:
  - mask is ignored and all CH channels are scanned.
  - No bubble cycles occur.

## Test plan
Use CH=4, W=8, DWELL=2, data = {8'h44, 8'h33, 8'h22, 8'h11} unless stated.
- Manual select: mode=0, out_ready=1, key=2 → after the next edge out=8'h33, out_ch=2, out_valid=1. Then key=3 → out=8'h44 one edge later.
- Scan with wrap: mode rises, out_ready=1 → successive out_ch = 0,0,1,1,2,2,3,3,0,0 with out = 11,11,22,22,33,33,44,44,11,11.
- Backpressure: in scan at out_ch=1 (first of pair), hold out_ready=0 for 5 cycles → out=8'h22 and out_ch=1 stable. After release the sequence continues 1,2,2,3, with no skip.
- Reset mid-scan: rst=1 for one cycle while out_ch=3 → out=0, out_ch=0, out_valid=0 after that edge. Release with mode=1 held → first load is channel 0 (mode_q re-edge).
- Mask (macro defined): mask=4'b1010 → out_ch values seen are only 1,1,3,3,1,1, with at most one out_valid=0 bubble per skip. mask=0 → out_valid=0 after the held sample is taken. The same run without the macro gives 0..3.
- Mode switching: scan at out_ch=2, set mode=0 with key=0 → next load out=8'h11, out_ch=0. Set mode=1 again → scan restarts at channel 0 with two loads of channel 0.
